// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/stall bundle between the pipeline datapath and pipeline_stall_ctrl.
// master = stall controller, slave = pipeline registers and hazard sources.
interface pipeline_stall_ctrl_if;
    logic        icache_hit;
    logic        dcache_hit;
    logic        mem_req;
    logic        idex_memread;
    logic [4:0]  idex_rt;
    logic [4:0]  ifid_rs;
    logic [4:0]  ifid_rt;
    logic        branch_taken;
    logic        pc_en;
    logic        ifid_en;
    logic        idex_en;
    logic        exmem_en;
    logic        memwb_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic [1:0]  state;
    logic        stall_err;
    logic [31:0] dstall_cnt;
    logic [31:0] istall_cnt;
    logic [31:0] bubble_cnt;

    modport master (
        input  icache_hit, dcache_hit, mem_req, idex_memread, idex_rt,
               ifid_rs, ifid_rt, branch_taken,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, state, stall_err,
               dstall_cnt, istall_cnt, bubble_cnt
    );

    modport slave (
        output icache_hit, dcache_hit, mem_req, idex_memread, idex_rt,
               ifid_rs, ifid_rt, branch_taken,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, state, stall_err,
               dstall_cnt, istall_cnt, bubble_cnt
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central freeze/bubble/squash sequencer for the 5-stage MIPS pipeline.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_stall_ctrl #(
    parameter int MISS_TIMEOUT = 64,
    parameter int CNT_W        = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    pipeline_stall_ctrl_if.master pif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ISTALL = 2'd1,
        DSTALL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(MISS_TIMEOUT);

    state_t           state_q;
    state_t           state_nxt;
    logic [CNT_W-1:0] miss_cnt;
    logic             stall_err_q;

    logic dmiss;
    logic imiss;
    logic lu;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush;
    logic in_stall;
    logic entering;

    always_comb begin
        dmiss = pif.mem_req & ~pif.dcache_hit;
        imiss = ~pif.icache_hit;
        lu    = pif.idex_memread & (pif.idex_rt != 5'd0) &
                ((pif.idex_rt == pif.ifid_rs) | (pif.idex_rt == pif.ifid_rt));

        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        state_nxt  = RUN;

        case (state_q)
            DSTALL: begin
                if (dmiss) begin
                    pc_en     = 1'b0;
                    ifid_en   = 1'b0;
                    idex_en   = 1'b0;
                    exmem_en  = 1'b0;
                    memwb_en  = 1'b0;
                    state_nxt = DSTALL;
                end else begin
                    // The releasing cycle lets the whole pipe advance once.
                    state_nxt = imiss ? ISTALL : RUN;
                end
            end
            default: begin
                if (dmiss) begin
                    // EX is frozen, so a taken branch stays valid until release.
                    pc_en     = 1'b0;
                    ifid_en   = 1'b0;
                    idex_en   = 1'b0;
                    exmem_en  = 1'b0;
                    memwb_en  = 1'b0;
                    state_nxt = DSTALL;
                end else if (pif.branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    state_nxt  = RUN;
                end else if (lu) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    state_nxt  = (state_q == ISTALL) ? ISTALL : RUN;
                end else if (imiss) begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                    state_nxt  = ISTALL;
                end
            end
        endcase

        if (!rstn) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
        end
    end

    assign in_stall = (state_q == ISTALL) | (state_q == DSTALL);
    assign entering = ((state_nxt == ISTALL) | (state_nxt == DSTALL)) &
                      (state_nxt != state_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= RUN;
            miss_cnt    <= '0;
            stall_err_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (entering) begin
                miss_cnt <= '0;
            end else if (in_stall && miss_cnt != TMO) begin
                miss_cnt <= miss_cnt + 1'b1;
                if (miss_cnt + 1'b1 == TMO)
                    stall_err_q <= 1'b1;
            end
        end
    end

    assign pif.pc_en      = pc_en;
    assign pif.ifid_en    = ifid_en;
    assign pif.idex_en    = idex_en;
    assign pif.exmem_en   = exmem_en;
    assign pif.memwb_en   = memwb_en;
    assign pif.ifid_flush = ifid_flush;
    assign pif.idex_flush = idex_flush;
    assign pif.state      = state_q;
    assign pif.stall_err  = stall_err_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] dstall_q, istall_q, bubble_q;

    // The flush pattern alone identifies which action was taken this cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dstall_q <= '0;
            istall_q <= '0;
            bubble_q <= '0;
        end else begin
            if (dmiss)
                dstall_q <= dstall_q + 32'd1;
            if (ifid_flush & ~idex_flush)
                istall_q <= istall_q + 32'd1;
            if (idex_flush & ~ifid_flush)
                bubble_q <= bubble_q + 32'd1;
        end
    end

    assign pif.dstall_cnt = dstall_q;
    assign pif.istall_cnt = istall_q;
    assign pif.bubble_cnt = bubble_q;
`else
    assign pif.dstall_cnt = 32'd0;
    assign pif.istall_cnt = 32'd0;
    assign pif.bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with hand-computed expectations.
module tb_pipeline_stall_ctrl;

    localparam logic [6:0] O_RST = 7'b00000_00;
    localparam logic [6:0] O_ALL = 7'b11111_00;
    localparam logic [6:0] O_FRZ = 7'b00000_00;
    localparam logic [6:0] O_BUB = 7'b00111_01;
    localparam logic [6:0] O_BR  = 7'b11111_11;
    localparam logic [6:0] O_IMS = 7'b01111_10;

    logic clk;
    logic rstn;
    int   total;
    int   bad;

    pipeline_stall_ctrl_if pif ();

    pipeline_stall_ctrl #(.MISS_TIMEOUT(64), .CNT_W(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .pif  (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {pif.pc_en, pif.ifid_en, pif.idex_en, pif.exmem_en, pif.memwb_en,
                pif.ifid_flush, pif.idex_flush};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        pif.icache_hit   = 1'b1;
        pif.dcache_hit   = 1'b1;
        pif.mem_req      = 1'b0;
        pif.idex_memread = 1'b0;
        pif.idex_rt      = 5'd0;
        pif.ifid_rs      = 5'd0;
        pif.ifid_rt      = 5'd0;
        pif.branch_taken = 1'b0;
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic step(input string tag, input logic [6:0] eo, input logic [1:0] es);
        #1;
        chk({tag, "_outs"}, 32'(outs()), 32'(eo));
        @(posedge clk);
        #1;
        chk({tag, "_state"}, 32'(pif.state), 32'(es));
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        idle_inputs();

        @(negedge clk);
        #1;
        chk("rst_outs", 32'(outs()), 32'(O_RST));
        chk("rst_state", 32'(pif.state), 32'd0);
        chk("rst_err", 32'(pif.stall_err), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        step("idle", O_ALL, 2'd0);

        pif.mem_req    = 1'b1;
        pif.dcache_hit = 1'b0;
        for (int i = 0; i < 3; i++) step("dmiss", O_FRZ, 2'd2);
        pif.dcache_hit = 1'b1;
        step("dexit", O_ALL, 2'd0);
        pif.mem_req = 1'b0;

        pif.idex_memread = 1'b1;
        pif.idex_rt      = 5'd5;
        pif.ifid_rs      = 5'd5;
        step("lu_rs", O_BUB, 2'd0);
        idle_inputs();
        step("lu_clear", O_ALL, 2'd0);
        pif.idex_memread = 1'b1;
        pif.idex_rt      = 5'd9;
        pif.ifid_rt      = 5'd9;
        step("lu_rt", O_BUB, 2'd0);
        idle_inputs();
        pif.idex_memread = 1'b1;
        step("lu_r0", O_ALL, 2'd0);

        pif.idex_rt      = 5'd7;
        pif.ifid_rs      = 5'd7;
        pif.icache_hit   = 1'b0;
        pif.branch_taken = 1'b1;
        step("br_ovr", O_BR, 2'd0);
        idle_inputs();

        pif.branch_taken = 1'b1;
        pif.mem_req      = 1'b1;
        pif.dcache_hit   = 1'b0;
        step("br_dmiss", O_FRZ, 2'd2);
        idle_inputs();
        step("br_dexit", O_ALL, 2'd0);

        pif.icache_hit = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step("imiss", O_IMS, 2'd1);
            if (i == 31) chk("err_mid", 32'(pif.stall_err), 32'd0);
        end
        pif.icache_hit = 1'b1;
        step("iexit", O_ALL, 2'd0);
        chk("err_set", 32'(pif.stall_err), 32'd1);
        step("idle2", O_ALL, 2'd0);
        chk("err_sticky", 32'(pif.stall_err), 32'd1);

`ifdef PIPE_PERF_CNT_EN
        chk("perf_d", pif.dstall_cnt, 32'd4);
        chk("perf_i", pif.istall_cnt, 32'd64);
        chk("perf_b", pif.bubble_cnt, 32'd2);
`else
        chk("perf_d", pif.dstall_cnt, 32'd0);
        chk("perf_i", pif.istall_cnt, 32'd0);
        chk("perf_b", pif.bubble_cnt, 32'd0);
`endif

        pif.mem_req    = 1'b1;
        pif.dcache_hit = 1'b0;
        step("pre_rst", O_FRZ, 2'd2);
        rstn = 1'b0;
        #1;
        chk("rst2_outs", 32'(outs()), 32'(O_RST));
        chk("rst2_state", 32'(pif.state), 32'd0);
        chk("rst2_err", 32'(pif.stall_err), 32'd0);
        @(negedge clk);
        #1;
        chk("rst2_hold", 32'(outs()), 32'(O_RST));
        idle_inputs();
        rstn = 1'b1;
        #1;
        chk("rel_state", 32'(pif.state), 32'd0);
        chk("rel_cnt", pif.dstall_cnt, 32'd0);
        @(negedge clk);
        step("rel_idle", O_ALL, 2'd0);

        pif.mem_req    = 1'b1;
        pif.dcache_hit = 1'b0;
        for (int i = 0; i < 10; i++) step("dmiss10", O_FRZ, 2'd2);
        pif.dcache_hit = 1'b1;
        step("dexit10", O_ALL, 2'd0);
        chk("err_after", 32'(pif.stall_err), 32'd0);
`ifdef PIPE_PERF_CNT_EN
        chk("perf_d10", pif.dstall_cnt, 32'd10);
`else
        chk("perf_d10", pif.dstall_cnt, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central hazard/stall sequencer for the 5-stage MIPS pipeline.
- Drives the per-stage enable (`hit`) inputs and the flush inputs of the IFID, IDEX, EXMEM and MEMWB pipeline registers, plus the PC enable.
- Arbitrates I-cache misses, D-cache misses, load-use hazards and taken branches into one consistent freeze/bubble/squash decision per cycle.

Parameters:
- MISS_TIMEOUT, 64: stall cycles in one miss episode after which stall_err is set.
- CNT_W, 8: width of the internal miss-episode counter; must hold MISS_TIMEOUT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- icache_hit  in  1  fetch word valid this cycle.
- dcache_hit  in  1  D-cache access completes this cycle.
- mem_req  in  1  instruction in EXMEM is a load/store.
- idex_memread  in  1  instruction in IDEX is a load.
- idex_rt  in  5  load destination in IDEX.
- ifid_rs  in  5  rs of instruction in IFID.
- ifid_rt  in  5  rt of instruction in IFID.
- branch_taken  in  1  branch/jump resolved taken in EX.
- pc_en  out  1  PC update enable.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register enables (`hit`).
- ifid_flush, idex_flush  out  1 each  load bubble (zero control bits) on next edge.
- state  out  2  current FSM state.
- stall_err  out  1  sticky miss-timeout flag.
- dstall_cnt, istall_cnt, bubble_cnt  out  32 each  performance counters (see Optional Feature).

Behaviour:
- Outputs are combinational from state and inputs; state, counters and stall_err are registered.
- Reset (rstn low, asynchronous): state=RUN(0), miss counter=0, stall_err=0, perf counters=0.
- While rstn is low: all enables=0, flushes=0.
- States: RUN=0, ISTALL=1, DSTALL=2. Encoding 3 is unused and decodes as RUN.
- Per-cycle signals:
  - dmiss = mem_req & !dcache_hit
  - imiss = !icache_hit
  - lu = idex_memread & (idex_rt!=0) & (idex_rt==ifid_rs | idex_rt==ifid_rt)
- Priority, highest first: dmiss > branch_taken > lu > imiss.
- Default (no event, any state resolving to run): all enables=1, flushes=0.
- dmiss (in any state):
  - pc_en=ifid_en=idex_en=exmem_en=memwb_en=0; the whole pipe holds.
  - branch_taken is ignored because EX is frozen and branch_taken stays valid.
  - Next state=DSTALL.
- DSTALL:
  - Holds while dmiss.
  - When dcache_hit: this cycle is the default all-enabled cycle, and next state=RUN, or ISTALL if imiss.
- branch_taken (no dmiss):
  - pc_en=1, ifid_flush=1, idex_flush=1; the IF and ID instructions are squashed.
  - Overrides lu and imiss; the mis-fetched word is discarded.
  - Next state=RUN.
- lu (no dmiss, no branch):
  - pc_en=0, ifid_en=0, idex_flush=1; one bubble.
  - Next state is unchanged (RUN) and the hazard clears naturally the next cycle.
- imiss (no dmiss, branch or lu):
  - pc_en=0, ifid_flush=1; downstream stages advance.
  - Next state=ISTALL. Exit to RUN on icache_hit.
- Miss counter:
  - Cleared on any transition into ISTALL or DSTALL.
  - Increments each cycle in those states and saturates at MISS_TIMEOUT.
  - When it reaches MISS_TIMEOUT, stall_err is set. stall_err is cleared only by reset.
- Reset mid-stall: immediate return to RUN. All stall and counter state is lost.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined: three 32-bit wrapping counters, cleared at reset:
  - dstall_cnt counts cycles with dmiss.
  - istall_cnt counts cycles with the imiss action taken.
  - bubble_cnt counts lu bubbles.
- Undefined: the counters are not built and the three ports are tied to 0.

Test Plan:
- Reset asserted mid-DSTALL (mem_req=1, dcache_hit=0) -> all enables 0 during reset; after release state=0, stall_err=0.
- mem_req=1, dcache_hit=0 for 3 cycles then 1 -> all enables 0 for 3 cycles, state=2, then all enables 1 and state=0.
- idex_memread=1, idex_rt=5, ifid_rs=5 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle only.
- Same load-use with idex_rt=0 -> no bubble.
- branch_taken=1 together with icache_hit=0 and a load-use hazard -> pc_en=1, ifid_flush=1, idex_flush=1, next state=0.
- branch_taken=1 with a simultaneous dmiss -> full freeze, no flush.
- icache_hit=0 for 64 cycles (MISS_TIMEOUT=64) -> state=1, stall_err rises after the 64th stall cycle and stays 1 after the hit.
- With PIPE_PERF_CNT_EN: 10 dmiss cycles -> dstall_cnt=10.
